imitator_sum: RTL

//  Downstream combiner for the imitator channels: sums I/Q of N channels in a pipelined adder tree.

---
 rtl/imitator_sum_pkg.sv | 23 ++
 rtl/imi_add_tree.sv | 59 +++++
 rtl/imitator_sum.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/imitator_sum_pkg.sv
// Shared widths, saturation limits and LFSR constants for the imitator channel combiner.
package imitator_sum_pkg;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  function automatic int sum_w(input int n_ch, input int in_w);
    return in_w + $clog2(n_ch);
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/imi_add_tree.sv
// Pipelined signed adder tree over N_CH packed inputs; one registered level per pairwise add.
// Latency $clog2(N_CH) cycles, one sum per clock, no stall path.
module imi_add_tree
  import imitator_sum_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int IN_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [N_CH*IN_WIDTH-1:0]           din,
  output logic [sum_w(N_CH, IN_WIDTH)-1:0]   sum
);

  localparam int T     = $clog2(N_CH);
  localparam int SUM_W = sum_w(N_CH, IN_WIDTH);
  localparam int HALF  = (N_CH + 1) / 2;

  // One spare zero slot per level lets an odd leftover pass through as x + 0.
  logic signed [SUM_W-1:0] src    [T+1][N_CH+1];
  logic signed [SUM_W-1:0] node_d [T][N_CH+1];
  logic signed [SUM_W-1:0] node_q [T][N_CH+1];

  always_comb begin
    for (int k = 0; k <= N_CH; k++) begin
      src[0][k] = '0;
    end
    for (int k = 0; k < N_CH; k++) begin
      src[0][k] = SUM_W'($signed(din[k*IN_WIDTH +: IN_WIDTH]));
    end
    for (int l = 1; l <= T; l++) begin
      for (int k = 0; k <= N_CH; k++) begin
        src[l][k] = node_q[l-1][k];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < T; l++) begin
      for (int k = 0; k <= N_CH; k++) begin
        node_d[l][k] = '0;
      end
      for (int k = 0; k < HALF; k++) begin
        node_d[l][k] = src[l][2*k] + src[l][2*k+1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      node_q <= '{default: '0};
    end else begin
      node_q <= node_d;
    end
  end

  assign sum = src[T][0];

endmodule

// File: rtl/imitator_sum.sv
// Sums I/Q of N_CH channels, applies rounded power-of-two gain, saturates to DAC width, counts clips.
// Latency $clog2(N_CH)+3 cycles, 1 sample/clk; IMI_SUM_NOISE_EN adds LFSR noise before the gain.
module imitator_sum
  import imitator_sum_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 14,
  parameter int SHIFT_W   = 5,
  parameter int NOISE_W   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH*IN_WIDTH-1:0] i_in,
  input  logic [N_CH*IN_WIDTH-1:0] q_in,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     noise_en,
  input  logic                     fix_pulse,
  output logic [OUT_WIDTH-1:0]     i_out,
  output logic [OUT_WIDTH-1:0]     q_out,
  output logic                     out_valid,
  output logic                     sat_flag,
  output logic [15:0]              sat_cnt
);

  localparam int T     = $clog2(N_CH);
  localparam int SUM_W = sum_w(N_CH, IN_WIDTH);
  localparam int RW    = SUM_W + 2;
  localparam int LAT   = T + 3;
  localparam int VC_W  = $clog2(LAT);
  localparam logic [VC_W-1:0]     V_LAST = VC_W'(LAT - 1);
  localparam logic signed [RW-1:0] HI_R  = RW'(sat_hi(OUT_WIDTH));
  localparam logic signed [RW-1:0] LO_R  = RW'(sat_lo(OUT_WIDTH));

  logic [N_CH*IN_WIDTH-1:0]  i_s0_d, i_s0_q, q_s0_d, q_s0_q;
  logic [SHIFT_W-1:0]        shift_pipe_d [T+1];
  logic [SHIFT_W-1:0]        shift_pipe_q [T+1];
  logic [SUM_W-1:0]          i_sum, q_sum;
  logic signed [NOISE_W-1:0] noise_i, noise_q;
  logic signed [RW-1:0]      i_rnd_d, i_rnd_q, q_rnd_d, q_rnd_q;
  logic [OUT_WIDTH:0]        i_sat, q_sat;
  logic [OUT_WIDTH-1:0]      i_out_d, i_out_q, q_out_d, q_out_q;
  logic                      sat_flag_d, sat_flag_q;
  logic [VC_W-1:0]           vcnt_d, vcnt_q;
  logic                      out_valid_d, out_valid_q;
  logic [15:0]               cnt_inc, cnt_d, cnt_q, sat_cnt_d, sat_cnt_q;

  // Round half up, then arithmetic shift; shifts past the sum width collapse to the sign.
  function automatic logic signed [RW-1:0] gain(input logic signed [SUM_W-1:0] s,
                                                input logic signed [NOISE_W-1:0] n,
                                                input logic [SHIFT_W-1:0] sh);
    logic signed [RW-1:0] v;
    v = RW'(s) + RW'(n);
    if (int'(sh) >= SUM_W) begin
      return v[RW-1] ? '1 : '0;
    end
    if (sh != '0) begin
      v = v + (RW'(1) << (sh - 1'b1));
    end
    return v >>> sh;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_WIDTH:0] sat(input logic signed [RW-1:0] v);
    if (v > HI_R) begin
      return {1'b1, HI_R[OUT_WIDTH-1:0]};
    end
    if (v < LO_R) begin
      return {1'b1, LO_R[OUT_WIDTH-1:0]};
    end
    return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    i_s0_d = '0;
    q_s0_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_en[k]) begin
        i_s0_d[k*IN_WIDTH +: IN_WIDTH] = i_in[k*IN_WIDTH +: IN_WIDTH];
        q_s0_d[k*IN_WIDTH +: IN_WIDTH] = q_in[k*IN_WIDTH +: IN_WIDTH];
      end
    end
    shift_pipe_d[0] = shift;
    for (int j = 1; j <= T; j++) begin
      shift_pipe_d[j] = shift_pipe_q[j-1];
    end
  end

  imi_add_tree #(.N_CH(N_CH), .IN_WIDTH(IN_WIDTH)) u_tree_i (
    .clk    (clk),
    .resetn (resetn),
    .din    (i_s0_q),
    .sum    (i_sum)
  );

  imi_add_tree #(.N_CH(N_CH), .IN_WIDTH(IN_WIDTH)) u_tree_q (
    .clk    (clk),
    .resetn (resetn),
    .din    (q_s0_q),
    .sum    (q_sum)
  );

`ifdef IMI_SUM_NOISE_EN
  logic [31:0]        lfsr_d, lfsr_q;
  logic               noise_en_s0_d, noise_en_s0_q;
  logic [NOISE_W-1:0] noise_pipe_d [T];
  logic [NOISE_W-1:0] noise_pipe_q [T];

  // Noise is picked alongside tree level 1 and delayed to meet the sums at the gain stage.
  always_comb begin
    lfsr_d          = lfsr_next(lfsr_q);
    noise_en_s0_d   = noise_en;
    noise_pipe_d[0] = noise_en_s0_q ? lfsr_q[NOISE_W-1:0] : '0;
    for (int j = 1; j < T; j++) begin
      noise_pipe_d[j] = noise_pipe_q[j-1];
    end
    noise_i = noise_pipe_q[T-1];
    noise_q = '0;
    for (int b = 0; b < NOISE_W; b++) begin
      noise_q[b] = noise_pipe_q[T-1][NOISE_W-1-b];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q        <= LFSR_SEED;
      noise_en_s0_q <= 1'b0;
      noise_pipe_q  <= '{default: '0};
    end else begin
      lfsr_q        <= lfsr_d;
      noise_en_s0_q <= noise_en_s0_d;
      noise_pipe_q  <= noise_pipe_d;
    end
  end
`else
  logic noise_en_unused;
  assign noise_en_unused = noise_en;
  assign noise_i = '0;
  assign noise_q = '0;
`endif

  always_comb begin
    i_rnd_d     = gain(signed'(i_sum), noise_i, shift_pipe_q[T]);
    q_rnd_d     = gain(signed'(q_sum), noise_q, shift_pipe_q[T]);
    i_sat       = sat(i_rnd_q);
    q_sat       = sat(q_rnd_q);
    i_out_d     = i_sat[OUT_WIDTH-1:0];
    q_out_d     = q_sat[OUT_WIDTH-1:0];
    sat_flag_d  = i_sat[OUT_WIDTH] | q_sat[OUT_WIDTH];
    vcnt_d      = (vcnt_q == V_LAST) ? vcnt_q : vcnt_q + 1'b1;
    out_valid_d = out_valid_q | (vcnt_q == V_LAST);
    // A hit in the fix_pulse cycle closes the old interval, not the new one.
    cnt_inc     = (sat_flag_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    cnt_d       = fix_pulse ? 16'd0 : cnt_inc;
    sat_cnt_d   = fix_pulse ? cnt_inc : sat_cnt_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_s0_q       <= '0;
      q_s0_q       <= '0;
      shift_pipe_q <= '{default: '0};
      i_rnd_q      <= '0;
      q_rnd_q      <= '0;
      i_out_q      <= '0;
      q_out_q      <= '0;
      sat_flag_q   <= 1'b0;
      vcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
      sat_cnt_q    <= '0;
    end else begin
      i_s0_q       <= i_s0_d;
      q_s0_q       <= q_s0_d;
      shift_pipe_q <= shift_pipe_d;
      i_rnd_q      <= i_rnd_d;
      q_rnd_q      <= q_rnd_d;
      i_out_q      <= i_out_d;
      q_out_q      <= q_out_d;
      sat_flag_q   <= sat_flag_d;
      vcnt_q       <= vcnt_d;
      out_valid_q  <= out_valid_d;
      cnt_q        <= cnt_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
